// File: rtl/inv_key_creation.sv
// Reverse AES-128 key schedule: walks from round key NUM_ROUNDS back to round 0, one key per transfer.
// Optional macro KEY_ZEROISE_EN clears the key and index registers once the final key is accepted.
`default_nettype none

module inv_key_creation #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         startTransition,
  input  logic [127:0] roundKeyInput,
  input  logic         roundKeyReady,
  output logic [127:0] roundKeyOutput,
  output logic [3:0]   roundKeyIndex,
  output logic         roundKeyValid,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] LOAD_INDEX = 4'(NUM_ROUNDS);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] rcon(input logic [3:0] round);
    case (round)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [127:0] key_next;
  logic [3:0]   index_next;
  logic         valid_next;
  logic         busy_next;
  logic         done_next;

  logic [31:0]  k0, k1, k2, k3;
  logic [31:0]  p0, p1, p2, p3;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [127:0] prev_key;
  logic         transfer;

  assign k0 = roundKeyOutput[31:0];
  assign k1 = roundKeyOutput[63:32];
  assign k2 = roundKeyOutput[95:64];
  assign k3 = roundKeyOutput[127:96];

  // Undo the forward recurrence: the upper three words come straight back by XOR,
  // and only word 0 needs the recovered word 3 of the previous round through SubWord.
  assign p3 = k3 ^ k2;
  assign p2 = k2 ^ k1;
  assign p1 = k1 ^ k0;

  assign rot_word = {p3[7:0], p3[31:8]};
  assign sub_word = {SBOX[rot_word[31:24]], SBOX[rot_word[23:16]],
                     SBOX[rot_word[15:8]],  SBOX[rot_word[7:0]]};

  assign p0       = k0 ^ sub_word ^ {24'h0, rcon(roundKeyIndex)};
  assign prev_key = {p3, p2, p1, p0};

  assign transfer = roundKeyValid & roundKeyReady;

  always_comb begin
    state_next = state;
    key_next   = roundKeyOutput;
    index_next = roundKeyIndex;
    valid_next = roundKeyValid;
    busy_next  = busy;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (startTransition) begin
          key_next   = roundKeyInput;
          index_next = LOAD_INDEX;
          valid_next = 1'b1;
          busy_next  = 1'b1;
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (transfer) begin
          if (roundKeyIndex != 4'd0) begin
            key_next   = prev_key;
            index_next = roundKeyIndex - 4'd1;
          end else begin
            valid_next = 1'b0;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = IDLE;
`ifdef KEY_ZEROISE_EN
            key_next   = '0;
            index_next = '0;
`endif
          end
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      roundKeyOutput <= '0;
      roundKeyIndex  <= '0;
      roundKeyValid  <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_next;
      roundKeyOutput <= key_next;
      roundKeyIndex  <= index_next;
      roundKeyValid  <= valid_next;
      busy           <= busy_next;
      done           <= done_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inv_key_creation.sv
// Directed bench for inv_key_creation: full-length (10 rounds) and single-round instances.
`default_nettype none

module tb_inv_key_creation;

  localparam logic [127:0] K10  = 128'h266f313bfea4c0cc4a24a46df8defd28;
  localparam logic [127:0] K9   = 128'hd8cbf1f7b48064a1b2fa594590bfe2bf;
  localparam logic [127:0] K8   = 128'h6c4b9556067a3de42245bbfa21ef518e;
  localparam logic [127:0] K1   = 128'h93a279d6e6e459b188911291f1fc32e2;
  localparam logic [127:0] K0   = 128'h754620676e754b20796d207374616854;
  localparam logic [127:0] KALT = 128'h0123456789abcdeffedcba9876543210;

  logic         clock = 1'b0;
  logic         reset;
  logic         start, ready;
  logic [127:0] kin;
  logic [127:0] key;
  logic [3:0]   idx;
  logic         valid, busy, done;

  logic         start1, ready1;
  logic [127:0] kin1;
  logic [127:0] key1;
  logic [3:0]   idx1;
  logic         valid1, busy1, done1;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  inv_key_creation #(.NUM_ROUNDS(10)) dut (
    .clock(clock), .reset(reset), .startTransition(start), .roundKeyInput(kin),
    .roundKeyReady(ready), .roundKeyOutput(key), .roundKeyIndex(idx),
    .roundKeyValid(valid), .busy(busy), .done(done)
  );

  inv_key_creation #(.NUM_ROUNDS(1)) dut1 (
    .clock(clock), .reset(reset), .startTransition(start1), .roundKeyInput(kin1),
    .roundKeyReady(ready1), .roundKeyOutput(key1), .roundKeyIndex(idx1),
    .roundKeyValid(valid1), .busy(busy1), .done(done1)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit key_known(input int r);
    return (r == 10) || (r == 9) || (r == 8) || (r == 1) || (r == 0);
  endfunction

  function automatic logic [127:0] key_expected(input int r);
    case (r)
      10:      return K10;
      9:       return K9;
      8:       return K8;
      1:       return K1;
      default: return K0;
    endcase
  endfunction

  // Checks the per-cycle view of an in-flight round r.
  task automatic check_round(input string tag, input int r);
    check({tag, "_idx"}, 128'(idx), 128'(r));
    check({tag, "_valid"}, 128'(valid), 128'd1);
    check({tag, "_busy"}, 128'(busy), 128'd1);
    check({tag, "_done"}, 128'(done), 128'd0);
    if (key_known(r)) check({tag, "_key"}, key, key_expected(r));
  endtask

  task automatic check_done_cycle(input string tag);
    check({tag, "_done"}, 128'(done), 128'd1);
    check({tag, "_busy"}, 128'(busy), 128'd0);
    check({tag, "_valid"}, 128'(valid), 128'd0);
    check({tag, "_idx"}, 128'(idx), 128'd0);
`ifdef KEY_ZEROISE_EN
    check({tag, "_key"}, key, 128'd0);
`else
    check({tag, "_key"}, key, K0);
`endif
  endtask

  initial begin
    int r;
    int cyc;

    reset = 1'b1; start = 1'b0; ready = 1'b0; kin = '0;
    start1 = 1'b0; ready1 = 1'b0; kin1 = '0;
    tick(); tick();
    check("rst_key", key, 128'd0);
    check("rst_idx", 128'(idx), 128'd0);
    check("rst_valid", 128'(valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    reset = 1'b0;
    tick();
    check("idle_valid", 128'(valid), 128'd0);

    // Ready held high: 11 consecutive keys then the done pulse.
    ready = 1'b1; kin = K10; start = 1'b1;
    tick();
    start = 1'b0; kin = KALT;
    for (int i = 10; i >= 0; i--) begin
      check_round("seq", i);
      tick();
    end
    check_done_cycle("seq_end");

    // Start in the done cycle is accepted; then ready follows 1,0,0,1,0,0,...
    start = 1'b1; kin = K10;
    tick();
    start = 1'b0; kin = KALT;
    r = 10; cyc = 0;
    while (r >= 0 && cyc < 200) begin
      ready = (cyc % 3 == 0);
      check_round("stall", r);
      tick();
      cyc++;
      if (ready) r--;
    end
    check("stall_bound", 128'(r), -128'sd1);
    check_done_cycle("stall_end");
    ready = 1'b1;
    tick();
    check("stall_done_pulse", 128'(done), 128'd0);

    // Start re-asserted at index 5 and at the final-transfer cycle must be ignored.
    kin = K10; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 10; i >= 0; i--) begin
      check_round("busy_start", i);
      start = (i == 5) || (i == 0);
      kin   = (i == 5 || i == 0) ? KALT : K10;
      tick();
    end
    start = 1'b0;
    check_done_cycle("busy_start_end");
    tick();
    check("busy_start_idle_valid", 128'(valid), 128'd0);

    // Reset in the middle of a sequence abandons it.
    kin = K10; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 10; i >= 7; i--) begin
      check_round("abort", i);
      tick();
    end
    check("abort_idx6", 128'(idx), 128'd6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_key", key, 128'd0);
    check("abort_idx", 128'(idx), 128'd0);
    check("abort_valid", 128'(valid), 128'd0);
    check("abort_busy", 128'(busy), 128'd0);
    check("abort_done", 128'(done), 128'd0);
    tick();
    check("abort_stays_idle", 128'(valid), 128'd0);
    kin = KALT; start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_idx", 128'(idx), 128'd10);
    check("restart_key", key, KALT);
    check("restart_valid", 128'(valid), 128'd1);
    for (int i = 0; i < 11; i++) tick();
    check("restart_done", 128'(done), 128'd1);
    check("restart_busy", 128'(busy), 128'd0);

    // Single-round instance.
    ready1 = 1'b1; kin1 = K1; start1 = 1'b1;
    tick();
    start1 = 1'b0; kin1 = KALT;
    check("r1_idx1", 128'(idx1), 128'd1);
    check("r1_key1", key1, K1);
    check("r1_valid1", 128'(valid1), 128'd1);
    tick();
    check("r1_idx0", 128'(idx1), 128'd0);
    check("r1_key0", key1, K0);
    check("r1_done_low", 128'(done1), 128'd0);
    tick();
    check("r1_done", 128'(done1), 128'd1);
    check("r1_busy", 128'(busy1), 128'd0);
    check("r1_valid", 128'(valid1), 128'd0);
`ifdef KEY_ZEROISE_EN
    check("r1_key_after", key1, 128'd0);
`else
    check("r1_key_after", key1, K0);
`endif
    tick();
    check("r1_done_pulse", 128'(done1), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
